uart_rx_top: RTL and testbench

// - 16550A-style UART receive engine; counterpart of uart_tx_top on the same serial line.
// - Oversamples rx on baud_pulse ticks, which come from the shared baud generator.
// - Frames 5-8 data bits, LSB first, with optional parity and at least one stop bit.
// - Emits one push strobe per frame with dout and pe/fe/bi status toward the RX FIFO/LSR logic.

---
 rtl/uart_rx_top_if.sv | 24 ++
 rtl/uart_rx_top.sv | 164 ++++++++++++++++
 tb/tb_uart_rx_top.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_top_if.sv
// Serial-side inputs, line-control settings and per-frame result strobe of the UART receiver.
interface uart_rx_top_if;
  logic       baud_pulse;
  logic       rx;
  logic       pen;
  logic       eps;
  logic       sticky_parity;
  logic [1:0] wls;
  logic       push;
  logic [7:0] dout;
  logic       pe;
  logic       fe;
  logic       bi;

  modport master (
    input  baud_pulse, rx, pen, eps, sticky_parity, wls,
    output push, dout, pe, fe, bi
  );

  modport slave (
    output baud_pulse, rx, pen, eps, sticky_parity, wls,
    input  push, dout, pe, fe, bi
  );
endinterface

// File: rtl/uart_rx_top.sv
// 16550A-style UART receive engine: oversampled start/data/parity/stop framing.
// Define RX_MAJORITY_EN to take each bit sample as a 2-of-3 vote over the last three ticks.
module uart_rx_top #(
  parameter int OVERSAMPLE = 16
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_top_if.master bus
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bitidx_q, bitidx_d;
  logic [7:0]    data_q, data_d;
  logic          rxpar_q, rxpar_d;
  logic          break_hold_q, break_hold_d;
  logic          push_q, push_d;
  logic [7:0]    dout_q, dout_d;
  logic          pe_q, pe_d;
  logic          fe_q, fe_d;
  logic          bi_q, bi_d;

  logic          sample;
  logic [2:0]    last_idx;
  logic          exp_par;

`ifdef RX_MAJORITY_EN
  // hist_q[0] is rx at the previous tick, hist_q[1] the one before; idle line resets to 1.
  logic [1:0] hist_q, hist_d;

  always_comb begin
    hist_d = hist_q;
    if (bus.baud_pulse) hist_d = {hist_q[0], bus.rx};
  end

  always_ff @(posedge clk) begin
    if (rst) hist_q <= 2'b11;
    else     hist_q <= hist_d;
  end

  assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & bus.rx) | (hist_q[0] & bus.rx);
`else
  assign sample = bus.rx;
`endif

  assign last_idx = {1'b0, bus.wls} + 3'd4;
  // data_q is cleared at frame start, so unused MSBs never disturb the parity reduction.
  assign exp_par  = bus.sticky_parity ? ~bus.eps : (bus.eps ? ^data_q : ~^data_q);

  always_comb begin
    // NOTE: combinational logic uses blocking '='; every _d is defaulted first so no latch is inferred.
    state_d      = state_q;
    cnt_d        = cnt_q;
    bitidx_d     = bitidx_q;
    data_d       = data_q;
    rxpar_d      = rxpar_q;
    break_hold_d = break_hold_q;
    push_d       = 1'b0;
    dout_d       = dout_q;
    pe_d         = pe_q;
    fe_d         = fe_q;
    bi_d         = bi_q;

    if (bus.baud_pulse) begin
      if (bus.rx) break_hold_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!break_hold_q && !bus.rx) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
        START: begin
          if (cnt_q == MID) begin
            cnt_d = '0;
            if (!sample) begin
              state_d  = DATA;
              bitidx_d = 3'd0;
              data_d   = 8'h00;
            end else begin
              state_d  = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (cnt_q == LAST) begin
            cnt_d            = '0;
            data_d[bitidx_q] = sample;
            if (bitidx_q == last_idx) state_d = bus.pen ? PARITY : STOP;
            else                      bitidx_d = bitidx_q + 3'd1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        PARITY: begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            rxpar_d = sample;
            state_d = STOP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
            push_d  = 1'b1;
            dout_d  = data_q;
            pe_d    = bus.pen & (rxpar_q != exp_par);
            fe_d    = ~sample;
            bi_d    = (data_q == 8'h00) & (~bus.pen | ~rxpar_q) & ~sample;
            if (bi_d) break_hold_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bitidx_q     <= 3'd0;
      data_q       <= 8'h00;
      rxpar_q      <= 1'b0;
      break_hold_q <= 1'b0;
      push_q       <= 1'b0;
      dout_q       <= 8'h00;
      pe_q         <= 1'b0;
      fe_q         <= 1'b0;
      bi_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bitidx_q     <= bitidx_d;
      data_q       <= data_d;
      rxpar_q      <= rxpar_d;
      break_hold_q <= break_hold_d;
      push_q       <= push_d;
      dout_q       <= dout_d;
      pe_q         <= pe_d;
      fe_q         <= fe_d;
      bi_q         <= bi_d;
    end
  end

  assign bus.push = push_q;
  assign bus.dout = dout_q;
  assign bus.pe   = pe_q;
  assign bus.fe   = fe_q;
  assign bus.bi   = bi_q;
endmodule

// File: tb/tb_uart_rx_top.sv
// Self-checking bench for uart_rx_top: directed vector table, hand-written corner sequences,
// and randomized frames checked against a frame-level reference model.
module tb_uart_rx_top;
  localparam int OS = 16;

  logic clk = 1'b0;
  logic rst;

  uart_rx_top_if bus();

  uart_rx_top #(.OVERSAMPLE(OS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // One baud tick every 6 clk.
  initial begin
    bus.baud_pulse = 1'b0;
    forever begin
      repeat (5) @(negedge clk);
      bus.baud_pulse = 1'b1;
      @(negedge clk);
      bus.baud_pulse = 1'b0;
    end
  end

  int         n_checks = 0;
  int         n_errors = 0;
  int         push_cnt = 0;
  logic [7:0] last_dout = 8'h00;
  logic       last_pe = 1'b0, last_fe = 1'b0, last_bi = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (bus.push === 1'b1) begin
        push_cnt++;
        last_dout = bus.dout;
        last_pe   = bus.pe;
        last_fe   = bus.fe;
        last_bi   = bus.bi;
      end
    end
  end

  typedef struct {
    logic [7:0] data;
    logic [1:0] wls;
    logic       pen, eps, sticky, par, stop;
    logic [7:0] exp_dout;
    logic       exp_pe, exp_fe, exp_bi;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (bus.baud_pulse !== 1'b1);
      @(negedge clk);
    end
  endtask

  task automatic line(input logic b, input int n);
    bus.rx = b;
    ticks(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] w, input logic pen_i,
                            input logic par, input logic stop, input int gap_bits);
    bus.wls = w;
    bus.pen = pen_i;
    line(1'b0, OS);
    for (int i = 0; i < int'(w) + 5; i++) line(d[i], OS);
    if (pen_i) line(par, OS);
    line(stop, OS);
    line(1'b1, gap_bits * OS);
  endtask

  task automatic expect_frame(input string name, input int prev, input logic [7:0] d,
                              input logic p, input logic f, input logic b);
    check({name, " push_count"}, push_cnt, prev + 1);
    check({name, " dout"}, {24'h0, last_dout}, {24'h0, d});
    check({name, " pe"}, {31'h0, last_pe}, {31'h0, p});
    check({name, " fe"}, {31'h0, last_fe}, {31'h0, f});
    check({name, " bi"}, {31'h0, last_bi}, {31'h0, b});
  endtask

  // Frame-level model: what a receiver must report for a given transmitted frame.
  function automatic void model(input logic [7:0] d, input logic [1:0] w, input logic pen_i,
                                input logic eps_i, input logic sticky_i, input logic par,
                                input logic stop, output logic [7:0] ed, output logic epe,
                                output logic efe, output logic ebi);
    int   ones = 0;
    logic want;
    ed = 8'h00;
    for (int i = 0; i < int'(w) + 5; i++) begin
      ed[i] = d[i];
      ones += int'(d[i]);
    end
    if (sticky_i)   want = ~eps_i;
    else if (eps_i) want = (ones % 2 == 1);
    else            want = (ones % 2 == 0);
    epe = pen_i && (par != want);
    efe = !stop;
    ebi = (ones == 0) && (!pen_i || !par) && !stop;
  endfunction

  initial begin
    int prev;
    logic [7:0] rd, ed;
    logic [1:0] rw;
    logic rpen, reps, rsticky, rpar, rstop, epe, efe, ebi;
    int gap;

    vecs[0]  = '{8'h13, 2'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h13, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'h13, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h13, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{8'h13, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h13, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{8'h13, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h13, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{8'h15, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h15, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{8'h5A, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{8'h7F, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{8'h3F, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3F, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{8'hFF, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1F, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{8'h00, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{8'h80, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0};

    bus.rx = 1'b1; bus.pen = 1'b0; bus.eps = 1'b0; bus.sticky_parity = 1'b0; bus.wls = 2'd3;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("reset push", {31'h0, bus.push}, 32'h0);
    check("reset dout", {24'h0, bus.dout}, 32'h0);
    check("reset flags", {29'h0, bus.pe, bus.fe, bus.bi}, 32'h0);
    rst = 1'b0;
    ticks(OS);
    check("idle no push", push_cnt, 0);

    // Directed vectors.
    for (int i = 0; i < 11; i++) begin
      prev = push_cnt;
      bus.eps = vecs[i].eps;
      bus.sticky_parity = vecs[i].sticky;
      send_frame(vecs[i].data, vecs[i].wls, vecs[i].pen, vecs[i].par, vecs[i].stop, 1);
      expect_frame($sformatf("vec%0d", i), prev, vecs[i].exp_dout,
                   vecs[i].exp_pe, vecs[i].exp_fe, vecs[i].exp_bi);
    end

    // 5N1 back-to-back, with push timing on the first stop-bit sample tick.
    bus.eps = 1'b0; bus.sticky_parity = 1'b0; bus.wls = 2'd0; bus.pen = 1'b0;
    prev = push_cnt;
    line(1'b0, OS);
    line(1'b1, OS); line(1'b0, OS); line(1'b1, OS); line(1'b0, OS); line(1'b1, OS);
    line(1'b1, OS / 2);
    check("b2b push before stop sample", {31'h0, bus.push}, 32'h0);
    ticks(1);
    check("b2b push at stop sample", {31'h0, bus.push}, 32'h1);
    ticks(OS / 2 - 1);
    expect_frame("b2b first", prev, 8'h15, 1'b0, 1'b0, 1'b0);
    send_frame(8'h03, 2'd0, 1'b0, 1'b0, 1'b1, 1);
    expect_frame("b2b second", prev + 1, 8'h03, 1'b0, 1'b0, 1'b0);

    // Break: 12 bit times low, then idle, then a normal frame.
    bus.eps = 1'b1; bus.wls = 2'd3; bus.pen = 1'b1;
    prev = push_cnt;
    line(1'b0, 12 * OS);
    expect_frame("break", prev, 8'h00, 1'b0, 1'b1, 1'b1);
    line(1'b1, OS);
    check("break single push", push_cnt, prev + 1);
    send_frame(8'h81, 2'd3, 1'b1, 1'b0, 1'b1, 1);
    expect_frame("after break", prev + 1, 8'h81, 1'b0, 1'b0, 1'b0);

    // False starts: 4-tick low pulse and 1-tick low pulse.
    bus.pen = 1'b0;
    prev = push_cnt;
    line(1'b0, 4);
    line(1'b1, 2 * OS);
    line(1'b0, 1);
    line(1'b1, 2 * OS);
    check("false start no push", push_cnt, prev);
    send_frame(8'h55, 2'd3, 1'b0, 1'b0, 1'b1, 1);
    expect_frame("after false start", prev, 8'h55, 1'b0, 1'b0, 1'b0);

`ifdef RX_MAJORITY_EN
    prev = push_cnt;
    bus.wls = 2'd3; bus.pen = 1'b0;
    line(1'b0, OS);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        line(1'b1, OS / 2 - 1); line(1'b0, 1); line(1'b1, OS / 2);
      end else begin
        line(1'b1, OS);
      end
    end
    line(1'b1, 2 * OS);
    expect_frame("glitch vote", prev, 8'hFF, 1'b0, 1'b0, 1'b0);
`endif

    // Reset during DATA of 0xA5.
    prev = push_cnt;
    bus.wls = 2'd3; bus.pen = 1'b0;
    line(1'b0, OS);
    line(1'b1, OS); line(1'b0, OS); line(1'b1, OS); line(1'b0, OS / 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    line(1'b1, 2 * OS);
    check("reset abort no push", push_cnt, prev);
    check("reset abort dout", {24'h0, bus.dout}, 32'h0);
    check("reset abort flags", {29'h0, bus.pe, bus.fe, bus.bi}, 32'h0);
    send_frame(8'h3C, 2'd3, 1'b0, 1'b0, 1'b1, 1);
    expect_frame("after reset", prev, 8'h3C, 1'b0, 1'b0, 1'b0);

    // Randomized frames against the model.
    for (int i = 0; i < 16; i++) begin
      rd      = 8'($urandom);
      if ($urandom_range(0, 7) == 0) rd = 8'h00;
      rw      = 2'($urandom_range(0, 3));
      rpen    = 1'($urandom_range(0, 1));
      reps    = 1'($urandom_range(0, 1));
      rsticky = 1'($urandom_range(0, 1));
      rpar    = 1'($urandom_range(0, 1));
      rstop   = ($urandom_range(0, 5) == 0) ? 1'b0 : 1'b1;
      gap     = rstop ? int'($urandom_range(0, 1)) : 1;
      model(rd, rw, rpen, reps, rsticky, rpar, rstop, ed, epe, efe, ebi);
      prev = push_cnt;
      bus.eps = reps;
      bus.sticky_parity = rsticky;
      send_frame(rd, rw, rpen, rpar, rstop, gap);
      expect_frame($sformatf("rand%0d", i), prev, ed, epe, efe, ebi);
    end

    line(1'b1, OS);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
